// File: rtl/spi_master_if.sv
// Bundle of the frame-request handshake and the SPI pins of spi_master.
// The master modport is the spi_master view; the slave modport is the client/bench view.
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, din, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, din, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Single-clock SPI master: select bit, 2-bit command and 8-bit payload out MSB first,
// then (read-data frames only) an optional turnaround gap and 8 bits received on MISO.
module spi_master #(
    parameter int TURNAROUND = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SHIFT,
        S_TURN,
        S_RECV,
        S_END
    } state_t;

    // Counters hold "cycles remaining after this one", so a state lasting N cycles loads N-1.
    localparam logic [3:0] SHIFT_LOAD = 4'd9;
    localparam logic [3:0] RECV_LOAD  = 4'd7;
    localparam logic [3:0] TURN_LOAD  = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    state_t     r_state;
    logic [9:0] r_shift;
    logic [1:0] r_cmd;
    logic [3:0] r_cnt;
    logic       r_ss_n;
    logic       r_mosi;
    logic       r_done;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;
    logic       w_read_data;

    assign w_read_data  = (r_cmd == 2'b11);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 10'd0;
            r_cmd      <= 2'b00;
            r_cnt      <= 4'd0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ss_n <= 1'b1;
                    r_mosi <= 1'b0;
                    if (bus.start) begin
                        r_shift <= {bus.cmd, bus.din};
                        r_cmd   <= bus.cmd;
                        r_ss_n  <= 1'b0;
                        r_mosi  <= bus.cmd[1];
                        r_state <= S_SEL;
                    end
                end
                S_SEL: begin
                    r_mosi  <= r_shift[9];
                    r_shift <= {r_shift[8:0], 1'b0};
                    r_cnt   <= SHIFT_LOAD;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt != 4'd0) begin
                        r_mosi  <= r_shift[9];
                        r_shift <= {r_shift[8:0], 1'b0};
                        r_cnt   <= r_cnt - 4'd1;
                    end else if (w_read_data) begin
                        r_mosi <= 1'b0;
                        if (TURNAROUND == 0) begin
                            r_cnt   <= RECV_LOAD;
                            r_state <= S_RECV;
                        end else begin
                            r_cnt   <= TURN_LOAD;
                            r_state <= S_TURN;
                        end
                    end else begin
                        r_ss_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_END;
                    end
                end
                S_TURN: begin
                    r_mosi <= 1'b0;
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_cnt   <= RECV_LOAD;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    // The transmit register is all zeros by now, so it doubles as the receiver.
                    r_mosi  <= 1'b0;
                    r_shift <= {r_shift[8:0], bus.MISO};
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rd_data  <= {r_shift[6:0], bus.MISO};
                        r_rd_valid <= 1'b1;
                        r_done     <= 1'b1;
                        r_ss_n     <= 1'b1;
                        r_state    <= S_END;
                    end
                end
                S_END: begin
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a RAM-style SPI slave on the pins, a transaction-level
// reference model of that RAM, directed scenarios and a randomized frame stream.
module tb_spi_master;
    localparam int TA = 2;

    logic clk;
    logic rst;
    spi_master_if bus ();

    spi_master #(.TURNAROUND(TA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pin monitor / slave state (written only by the monitor process).
    int          mon_cyc     = 0;
    logic [10:0] mon_bits    = '0;
    logic [10:0] last_bits   = '0;
    int          last_low    = 0;
    int          frames_seen = 0;
    int          high_run    = 0;
    int          done_cnt    = 0;
    int          rv_cnt      = 0;
    int          mosi_bad    = 0;
    bit          prev_frame  = 1'b0;
    bit          s_init      = 1'b0;
    int          gap_q[$];
    logic [7:0]  s_mem [256];
    logic [7:0]  s_addr      = 8'h00;
    logic [7:0]  s_tx        = 8'h00;

    // Reference model state (written only by the stimulus process).
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_addr = 8'h00;
    logic [7:0]  ref_rd   = 8'h00;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void slave_exec(input logic [10:0] b);
        case (b[9:8])
            2'b00, 2'b10: s_addr = b[7:0];
            2'b01:        s_mem[s_addr] = b[7:0];
            default:      s_tx = s_mem[s_addr];
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Everything is observed on the falling edge, half a cycle away from the DUT's edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!s_init) begin
                    for (int i = 0; i < 256; i++) s_mem[i] = init_byte(i);
                    s_init = 1'b1;
                end
                mon_cyc    = 0;
                high_run   = 0;
                prev_frame = 1'b0;
                bus.MISO   = 1'b0;
            end else begin
                if (bus.done) done_cnt++;
                if (bus.rd_valid) rv_cnt++;
                if (!bus.SS_n) begin
                    if (mon_cyc == 0 && prev_frame) gap_q.push_back(high_run);
                    if (mon_cyc < 11) mon_bits = {mon_bits[9:0], bus.MOSI};
                    else if (bus.MOSI) mosi_bad++;
                    if (mon_cyc == 10) slave_exec(mon_bits);
                    if (mon_cyc >= 11 + TA && mon_cyc < 19 + TA) bus.MISO = s_tx[18 + TA - mon_cyc];
                    else bus.MISO = 1'($urandom);
                    mon_cyc++;
                    high_run = 0;
                end else begin
                    if (mon_cyc != 0) begin
                        last_low   = mon_cyc;
                        last_bits  = mon_bits;
                        frames_seen++;
                        prev_frame = 1'b1;
                    end
                    if (bus.MOSI) mosi_bad++;
                    mon_cyc  = 0;
                    high_run++;
                    bus.MISO = 1'($urandom);
                end
            end
        end
    end

    // Issue one frame from an IDLE cycle and check it end to end.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d);
        int n;
        int dc0;
        int rv0;
        int mb0;
        int fs0;
        int exp_low;
        exp_low = (c == 2'b11) ? 19 + TA : 11;
        case (c)
            2'b00, 2'b10: ref_addr = d;
            2'b01:        ref_mem[ref_addr] = d;
            default:      ref_rd = ref_mem[ref_addr];
        endcase
        dc0 = done_cnt;
        rv0 = rv_cnt;
        mb0 = mosi_bad;
        fs0 = frames_seen;
        bus.cmd   = c;
        bus.din   = d;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.cmd   = 2'($urandom);
        bus.din   = 8'($urandom);
        check("busy_sel", 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_latency", n, exp_low + 1);
        check("ss_low_len", last_low, exp_low);
        check("mosi_bits", 32'(last_bits), 32'({c[1], c, d}));
        check("rd_valid", 32'(bus.rd_valid), 32'(c == 2'b11));
        check("rd_data", 32'(bus.rd_data), 32'(ref_rd));
        check("mosi_idle_zero", mosi_bad, mb0);
        check("frame_count", frames_seen, fs0 + 1);
        $display("frame cmd=%b din=%02h ss_low=%0d rd_data=%02h", c, d, last_low, bus.rd_data);
        @(negedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("rdv_pulse", 32'(bus.rd_valid), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("done_count", done_cnt, dc0 + 1);
        check("rdv_count", rv_cnt, rv0 + ((c == 2'b11) ? 1 : 0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dc0;
        int fs0;
        int g0;
        logic [7:0] d;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.cmd   = 2'b00;
        bus.din   = 8'h00;

        // Reset must act without any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_ss_n", 32'(bus.SS_n), 32'd1);
        check("rst_mosi", 32'(bus.MOSI), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdv", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Write address A5, then a read-data frame returning 3C.
        run_frame(2'b00, 8'hA5);
        run_frame(2'b00, 8'h40);
        run_frame(2'b01, 8'h3C);
        run_frame(2'b11, 8'h77);
        check("rd_3c", 32'(bus.rd_data), 32'h3C);

        // Full RAM transaction.
        run_frame(2'b00, 8'h10);
        run_frame(2'b01, 8'h5A);
        run_frame(2'b10, 8'h10);
        run_frame(2'b11, 8'h00);
        check("ram_rd_5a", 32'(bus.rd_data), 32'h5A);

        // start pulses during SHIFT and during END are ignored.
        dc0 = done_cnt;
        fs0 = frames_seen;
        ref_addr  = 8'h33;
        bus.cmd   = 2'b00;
        bus.din   = 8'h33;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        bus.cmd   = 2'b01;
        bus.din   = 8'hEE;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("ign_done", done_cnt, dc0 + 1);
        check("ign_frames", frames_seen, fs0 + 1);
        check("ign_bits", 32'(last_bits), 32'({1'b0, 2'b00, 8'h33}));
        $display("frame cmd=00 din=33 with ignored starts, frames=%0d", frames_seen - fs0);

        // Reset in the middle of a write-data frame, then a clean read.
        dc0 = done_cnt;
        bus.cmd   = 2'b01;
        bus.din   = 8'hC3;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        ref_rd = 8'h00;
        #1;
        check("abort_ss_n", 32'(bus.SS_n), 32'd1);
        check("abort_mosi", 32'(bus.MOSI), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rd_data", 32'(bus.rd_data), 32'h00);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        check("abort_no_done", done_cnt, dc0);
        $display("frame cmd=01 din=c3 aborted by reset");
        run_frame(2'b11, 8'($urandom));

        // start held high: back-to-back read-address frames.
        g0  = gap_q.size();
        fs0 = frames_seen;
        dc0 = done_cnt;
        d   = 8'h21;
        ref_addr  = d;
        bus.cmd   = 2'b10;
        bus.din   = d;
        bus.start = 1'b1;
        n = 0;
        while (frames_seen < fs0 + 4 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        check("b2b_frames", frames_seen, fs0 + 4);
        check("b2b_ngaps", gap_q.size() - g0, 4);
        for (int i = g0 + 1; i < gap_q.size(); i++) check("b2b_gap", gap_q[i], 2);
        check("b2b_low", last_low, 11);
        check("b2b_bits", 32'(last_bits), 32'({1'b1, 2'b10, d}));
        @(negedge clk); #1;
        check("b2b_done", done_cnt, dc0 + 4);
        $display("frames cmd=10 din=21 back-to-back count=%0d", frames_seen - fs0);

        // Randomized frame stream against the reference RAM.
        for (int k = 0; k < 40; k++) begin
            run_frame(2'($urandom_range(0, 3)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter TURNAROUND, default 2, SS_n-low idle cycles between last MOSI bit and first MISO sample on read-data frames (legal 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge; SPI bit rate is one bit per clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  frame request; accepted only on a rising edge where busy=0.
REQ-005 cmd  input  2  frame command: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-006 din  input  8  frame payload (address or data; don't-care content for cmd=11, still transmitted).
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse at frame completion.
REQ-009 rd_data  output  8  byte received on MISO in the last read-data frame; holds until next read-data frame completes.
REQ-010 rd_valid  output  1  one-cycle pulse coincident with done, only for cmd=11 frames.
REQ-011 SS_n  output  1  slave select, active-low, registered.
REQ-012 MOSI  output  1  serial data to slave, registered, MSB first.
REQ-013 MISO  input  1  serial data from slave, sampled only in RECV.

Function
REQ-014 States: IDLE, SEL, SHIFT, TURN, RECV, END; encoding implementer's choice.
REQ-015 IDLE: SS_n=1, MOSI=0; on start=1 latch {cmd,din} into 10-bit shift register and a copy of cmd, go to SEL.
REQ-016 SEL: one cycle, SS_n=0, MOSI=cmd[1] (0 = write frame, 1 = read frame select bit); go to SHIFT.
REQ-017 SHIFT: exactly 10 cycles, SS_n=0, MOSI = shift[9] then shift left each cycle (cmd[1], cmd[0], din[7]..din[0]).
REQ-018 After SHIFT: cmd=11 -> TURN (or RECV directly if TURNAROUND=0); any other cmd -> END.
REQ-019 TURN: TURNAROUND cycles, SS_n=0, MOSI=0.
REQ-020 RECV: exactly 8 cycles, SS_n=0, MOSI=0; MISO sampled at the rising edge ending each cycle, shifted in MSB first.
REQ-021 END: one cycle, SS_n=1, MOSI=0, done=1; for cmd=11 rd_data takes the 8 received bits at entry to END and rd_valid=1; next state IDLE.
REQ-022 Minimum SS_n-high gap between frames: 2 cycles (END + one IDLE cycle); start asserted during END is ignored.
REQ-023 start while busy=1 is ignored; cmd/din changes while busy=1 do not affect the frame in progress.
REQ-024 Latency, start accepted at edge k: SS_n low for edges k+1..k+11 (non-read-data) -> done high in cycle after edge k+11; read-data: SS_n low 11+TURNAROUND+8 cycles, done after.
REQ-025 Bit and turnaround counters saturate-free: 4-bit counter, reloaded on every state entry; no wrap beyond state lengths.
REQ-026 Back-to-back: start held high continuously yields frames separated by exactly 2 SS_n-high cycles.

Reset
REQ-027 rst=1 forces immediately (no clock): state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, shift register and counters 0.
REQ-028 rst mid-frame aborts it: SS_n returns high asynchronously, no done or rd_valid pulse; first accepted start after rst release starts a fresh frame at SEL.

Verification
REQ-029 Write address: cmd=00, din=8'hA5, start 1 cycle -> SS_n low 11 cycles, MOSI = 0,0,0,1,0,1,0,0,1,0,1; done 1 cycle; rd_valid stays 0.
REQ-030 Read data, TURNAROUND=2: cmd=11, slave model drives MISO 8'h3C in RECV -> SS_n low 21 cycles, MOSI select bit 1, rd_data=8'h3C with rd_valid=done=1 same cycle.
REQ-031 Full RAM transaction against the slave wrapper: write addr 8'h10, write data 8'h5A, read addr 8'h10, read data -> rd_data=8'h5A.
REQ-032 start pulsed during SHIFT and during END -> ignored; exactly one frame, one done.
REQ-033 rst asserted at SHIFT bit 5 of a cmd=01 frame -> SS_n=1 and MOSI=0 within same cycle, no done; subsequent frame correct.
REQ-034 start held high, cmd=10 -> repeated frames, SS_n high exactly 2 cycles between each.
